// File: rtl/audio_vis_pkg.sv
// Shared constants and types for the audio visualizer capture path.
package audio_vis_pkg;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned MEM_WORDS = 23719;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/audio_word_fifo.sv
// Synchronous 32-bit word FIFO with registered occupancy count.
// Also exposes the word that will be at the head after a pop this cycle.
module audio_word_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                head_o,
  output logic [31:0]                next_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  // Head after a pop: the second stored entry, or the word being pushed
  // this cycle when only one entry is stored.
  always_comb begin
    next_o = wdata_i;
    if (count_q > CW'(1)) begin
      next_o = mem_q[rd_q + 1'b1];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/audio_ring_writer.sv
// Avalon-MM write master: packs stereo sample pairs into 32-bit words and
// streams them into a ring region of on-chip RAM, pulsing at half and full
// ring boundaries for software double-buffering.
module audio_ring_writer #(
  parameter int unsigned ADDR_W     = audio_vis_pkg::ADDR_W,
  parameter int unsigned BASE_WORD  = 0,
  parameter int unsigned LEN_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                snk_valid,
  input  logic [audio_vis_pkg::SAMPLE_W-1:0]  snk_left,
  input  logic [audio_vis_pkg::SAMPLE_W-1:0]  snk_right,
  output logic [ADDR_W-1:0]                   avm_address,
  output logic [3:0]                          avm_byteenable,
  output logic                                avm_chipselect,
  output logic                                avm_write,
  output logic [31:0]                         avm_writedata,
  input  logic                                avm_waitrequest,
  input  logic                                clear_overflow,
  output logic [ADDR_W-1:0]                   wr_ptr,
  output logic                                half_done,
  output logic                                wrap_done,
  output logic                                overflow
);

  import audio_vis_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(BASE_WORD + LEN_WORDS - 1);
  localparam logic [ADDR_W-1:0] A_HALF = ADDR_W'(BASE_WORD + LEN_WORDS / 2 - 1);

  if (BASE_WORD + LEN_WORDS > MEM_WORDS || LEN_WORDS < 2 || (LEN_WORDS % 2) != 0)
  begin : g_bad_ring
    $error("audio_ring_writer: invalid ring geometry");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("audio_ring_writer: FIFO_DEPTH must be a power of 2 >= 2");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                half_q, half_d;
  logic                wrap_q, wrap_d;
  logic                ovf_q, ovf_d;

  logic                push;
  logic                push_ok;
  logic                pop;
  logic                accept;
  logic [31:0]         fifo_head;
  logic [31:0]         fifo_next;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       cnt_after;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ADDR_W-1:0]   ptr_inc;

  assign push    = snk_valid & enable;
  assign push_ok = push & ~fifo_full;
  assign accept  = write_q & ~avm_waitrequest;
  assign pop     = accept;
  assign ptr_inc = (ptr_q == A_LAST) ? A_BASE : ptr_q + 1'b1;

  audio_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({snk_left, snk_right}),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Occupancy once this cycle's accept and push have both landed; only
  // consulted in WRITE, where at least one word is stored.
  assign cnt_after = fifo_count - CW'(1) + CW'(push_ok);

  // Next-state, bus outputs, ring pointer and flag logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    ptr_d   = ptr_q;
    half_d  = 1'b0;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    if (push & fifo_full) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WRITE;
          write_d = 1'b1;
          addr_d  = ptr_q;
          data_d  = fifo_head;
        end
      end
      WRITE: begin
        if (accept) begin
          ptr_d  = ptr_inc;
          half_d = (addr_q == A_HALF);
          wrap_d = (addr_q == A_LAST);
          if (cnt_after != '0) begin
            addr_d = ptr_inc;
            data_d = fifo_next;
          end else begin
            state_d = IDLE;
            write_d = 1'b0;
            addr_d  = '0;
            data_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      ptr_q   <= A_BASE;
      half_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      ptr_q   <= ptr_d;
      half_q  <= half_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign avm_write      = write_q;
  assign avm_chipselect = write_q;
  assign avm_byteenable = {4{write_q}};
  assign wr_ptr         = ptr_q;
  assign half_done      = half_q;
  assign wrap_done      = wrap_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_audio_ring_writer.sv
// Directed bench for audio_ring_writer with a queue-based reference model.
module tb_audio_ring_writer;

  localparam int unsigned AW    = 15;
  localparam int unsigned BASE  = 0;
  localparam int unsigned LEN   = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          snk_valid = 1'b0;
  logic [15:0]   snk_left = '0;
  logic [15:0]   snk_right = '0;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_chipselect;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [AW-1:0] wr_ptr;
  logic          half_done;
  logic          wrap_done;
  logic          overflow;

  always #5 clk = ~clk;

  audio_ring_writer #(
    .ADDR_W     (AW),
    .BASE_WORD  (BASE),
    .LEN_WORDS  (LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .snk_valid       (snk_valid),
    .snk_left        (snk_left),
    .snk_right       (snk_right),
    .avm_address     (avm_address),
    .avm_byteenable  (avm_byteenable),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .clear_overflow  (clear_overflow),
    .wr_ptr          (wr_ptr),
    .half_done       (half_done),
    .wrap_done       (wrap_done),
    .overflow        (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of stored words plus the word on the bus.
  logic [31:0] mq[$];
  bit          m_write = 0;
  int unsigned m_addr = 0;
  int unsigned m_ptr = BASE;
  logic [31:0] m_data = '0;
  bit          m_half = 0;
  bit          m_wrap = 0;
  bit          m_ovf = 0;
  bit          started = 0;
  bit          was_full, acc, had;
  int unsigned off;

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      mq.delete();
      m_write = 0; m_addr = 0; m_data = '0; m_ptr = BASE;
      m_half = 0; m_wrap = 0; m_ovf = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      acc      = m_write && !avm_waitrequest;
      had      = (mq.size() != 0);
      m_half   = 0;
      m_wrap   = 0;
      if (snk_valid && enable && was_full) m_ovf = 1;
      else if (clear_overflow)             m_ovf = 0;
      if (snk_valid && enable && !was_full) mq.push_back({snk_left, snk_right});
      if (acc) begin
        off    = m_addr - BASE;
        m_half = (off == LEN / 2 - 1);
        m_wrap = (off == LEN - 1);
        void'(mq.pop_front());
        m_ptr  = BASE + (m_ptr - BASE + 1) % LEN;
      end
      if (m_write && !acc) begin
        // stalled: bus holds
      end else if ((m_write && mq.size() != 0) || (!m_write && had)) begin
        m_write = 1; m_addr = m_ptr; m_data = mq[0];
      end else begin
        m_write = 0; m_addr = 0; m_data = '0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("avm_write",      32'(avm_write),      32'(m_write));
      chk("avm_chipselect", 32'(avm_chipselect), 32'(m_write));
      chk("avm_byteenable", 32'(avm_byteenable), m_write ? 32'hF : 32'h0);
      chk("avm_address",    32'(avm_address),    m_addr);
      chk("avm_writedata",  avm_writedata,       m_data);
      chk("wr_ptr",         32'(wr_ptr),         m_ptr);
      chk("half_done",      32'(half_done),      32'(m_half));
      chk("wrap_done",      32'(wrap_done),      32'(m_wrap));
      chk("overflow",       32'(overflow),       32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          n_acc;
  logic [31:0] got_addr [16];
  logic [31:0] got_data [16];
  int          half_at, wrap_at;
  logic [31:0] ptr_at_wrap;

  initial begin
    // Reset
    repeat (3) step();
    chk("rst_write", 32'(avm_write), 32'h0);
    chk("rst_be",    32'(avm_byteenable), 32'h0);
    chk("rst_ptr",   32'(wr_ptr), BASE);
    chk("rst_ovf",   32'(overflow), 32'h0);
    reset = 1'b0;
    repeat (2) step();

    // Single pair: bus write two cycles after the strobe
    snk_valid = 1'b1; snk_left = 16'h1234; snk_right = 16'hABCD;
    step();
    snk_valid = 1'b0;
    chk("t1_n1_write", 32'(avm_write), 32'h0);
    step();
    chk("t1_write", 32'(avm_write), 32'h1);
    chk("t1_addr",  32'(avm_address), 32'h0);
    chk("t1_data",  avm_writedata, 32'h1234ABCD);
    chk("t1_be",    32'(avm_byteenable), 32'hF);
    step();
    chk("t1_ptr",   32'(wr_ptr), 32'h1);
    chk("t1_done",  32'(avm_write), 32'h0);
    repeat (2) step();

    // Six strobes into a stalled bus: four stored, two dropped
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      snk_valid = 1'b1;
      snk_left  = 16'h1000 + 16'(i);
      snk_right = 16'h2000 + 16'(i);
      step();
    end
    snk_valid = 1'b0;
    chk("t2_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_stall_write", 32'(avm_write), 32'h1);
      chk("t2_stall_addr",  32'(avm_address), 32'h1);
      chk("t2_stall_data",  avm_writedata, 32'h10002000);
      step();
    end
    avm_waitrequest = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (avm_write && n_acc < 16) begin
        got_addr[n_acc] = 32'(avm_address);
        got_data[n_acc] = avm_writedata;
        n_acc++;
      end
      step();
    end
    chk("t2_count", 32'(n_acc), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_addr", got_addr[k], 32'(k + 1));
      chk("t2_data", got_data[k], {16'h1000 + 16'(k), 16'h2000 + 16'(k)});
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("t2_clear", 32'(overflow), 32'h0);

    // Ring wrap with LEN=8: nine pairs back to back
    reset = 1'b1; step();
    reset = 1'b0; step();
    n_acc = 0; half_at = -1; wrap_at = -1; ptr_at_wrap = 32'hFFFF_FFFF;
    for (int it = 0; it < 24; it++) begin
      snk_valid = (it < 9);
      snk_left  = 16'h3000 + 16'(it);
      snk_right = 16'h4000 + 16'(it);
      if (avm_write && n_acc < 16) begin
        got_addr[n_acc] = 32'(avm_address);
        n_acc++;
      end
      step();
      if (half_done) half_at = n_acc;
      if (wrap_done) begin
        wrap_at = n_acc;
        ptr_at_wrap = 32'(wr_ptr);
      end
    end
    snk_valid = 1'b0;
    chk("t3_count",    32'(n_acc), 32'd9);
    chk("t3_half_at",  32'(half_at), 32'd4);
    chk("t3_wrap_at",  32'(wrap_at), 32'd8);
    chk("t3_wrap_ptr", ptr_at_wrap, 32'h0);
    chk("t3_addr3",    got_addr[3], 32'd3);
    chk("t3_addr7",    got_addr[7], 32'd7);
    chk("t3_addr8",    got_addr[8], 32'd0);
    chk("t3_ptr_end",  32'(wr_ptr), 32'd1);

    // Enable dropped during a stalled write
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      snk_valid = 1'b1; snk_left = 16'h5000 + 16'(i); snk_right = 16'h6000;
      step();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      snk_valid = 1'b1; snk_left = 16'h7000 + 16'(i);
      step();
    end
    snk_valid = 1'b0;
    chk("t4_stalled", 32'(avm_write), 32'h1);
    step();
    avm_waitrequest = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (avm_write) n_acc++;
      step();
    end
    chk("t4_count", 32'(n_acc), 32'd2);
    chk("t4_ovf",   32'(overflow), 32'h0);
    chk("t4_idle",  32'(avm_write), 32'h0);
    enable = 1'b1;

    // Overflow set beats a simultaneous clear
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      snk_valid = 1'b1; snk_left = 16'h8000 + 16'(i); snk_right = 16'h9000;
      step();
    end
    clear_overflow = 1'b1;
    step();
    snk_valid = 1'b0;
    chk("t5_set_wins", 32'(overflow), 32'h1);
    step();
    clear_overflow = 1'b0;
    chk("t5_clear", 32'(overflow), 32'h0);

    // Reset during a stalled write
    chk("t6_pre_write", 32'(avm_write), 32'h1);
    reset = 1'b1;
    step();
    chk("t6_write", 32'(avm_write), 32'h0);
    chk("t6_cs",    32'(avm_chipselect), 32'h0);
    chk("t6_be",    32'(avm_byteenable), 32'h0);
    chk("t6_addr",  32'(avm_address), 32'h0);
    chk("t6_ptr",   32'(wr_ptr), BASE);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (3) step();
    chk("t6_empty", 32'(avm_write), 32'h0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
